// File: rtl/div_mod_32bit_pkg.sv
// Shared width, FSM encoding and divide-by-zero constants for the 32-bit divider.
package div_mod_32bit_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

endpackage

// File: rtl/div_mod_32bit_div_step.sv
// One restoring shift-subtract step of the divider.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when to use the result.
module div_step
    import div_mod_32bit_pkg::*;
(
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // The 33rd shifted bit set means the partial remainder already exceeds any
    // 32-bit divisor; the low-bit difference is then exact because rem < divisor.
    always_comb begin
        shifted = {rem, dividend_msb};
        diff    = shifted[WIDTH-1:0] - divisor;
        q_bit   = shifted[WIDTH] | (shifted[WIDTH-1:0] >= divisor);
        rem_nxt = q_bit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_mod_32bit.sv
// Unsigned 32-bit sequential divider producing quotient and remainder.
// Latency: 33 cycles from accepted start to done (1 cycle when B == 0).
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
module div_mod_32bit
    import div_mod_32bit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem_work;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_step u_step (
        .rem          (rem_work),
        .dividend_msb (dividend[WIDTH-1]),
        .divisor      (divisor),
        .rem_nxt      (step_rem),
        .q_bit        (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (B == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN:     state_nxt = (count == 5'd31) ? DONE : RUN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Quotient bits are shifted into the vacated low end of the dividend, so
    // after 32 steps the dividend register holds the full quotient.
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            dividend    <= '0;
            divisor     <= '0;
            rem_work    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            quotient    <= DIV0_QUOTIENT;
                            remainder   <= A;
                            div_by_zero <= 1'b1;
                        end else begin
                            dividend    <= A;
                            divisor     <= B;
                            rem_work    <= '0;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    dividend <= {dividend[WIDTH-2:0], step_qbit};
                    rem_work <= step_rem;
                    count    <= count + 5'd1;
                    if (count == 5'd31) begin
                        quotient  <= {dividend[WIDTH-2:0], step_qbit};
                        remainder <= step_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/div_mod_32bit.md
DIV_MOD_32BIT -- requirements
Module: div_mod_32bit

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on rising clk edge.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  32  unsigned dividend; captured when start is accepted.
REQ-006 B  input  32  unsigned divisor; captured when start is accepted.
REQ-007 busy  output  1  high while an operation is in progress (RUN state).
REQ-008 done  output  1  one-cycle pulse when the result becomes valid.
REQ-009 quotient  output  32  A / B, unsigned.
REQ-010 remainder  output  32  A mod B, unsigned.
REQ-011 div_by_zero  output  1  set with done when the captured B == 0; held until the next accepted start.

Function
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE, encoded in 2 bits.
REQ-013 IDLE, start=1 and B!=0: capture A into the dividend shift register, capture B, clear the partial remainder and the 5-bit count, and go to RUN.
REQ-014 IDLE, start=1 and B==0: go directly to DONE; quotient=32'hFFFFFFFF, remainder=A, div_by_zero=1.
REQ-015 RUN: perform one restoring shift-subtract step per cycle, MSB first.
  - rem' = {rem[30:0], dividend[31]}
  - if rem' >= B, then rem' -= B and the quotient bit is 1; otherwise the quotient bit is 0.
REQ-016 The compare/subtract SHALL be 33 bits wide so that it never overflows.
REQ-017 RUN SHALL last exactly 32 cycles; when count==31, go to DONE.
REQ-018 DONE SHALL last exactly 1 cycle, with done=1 and busy=0, then return to IDLE.
REQ-019 Latency: for B!=0, done SHALL be high in the 33rd cycle after the edge that accepted start; for B==0, in the 1st cycle after that edge.
REQ-020 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-021 start asserted while in RUN or DONE SHALL be ignored; it is not queued.
REQ-022 Changes on A or B after acceptance SHALL NOT affect the operation in flight.
REQ-023 busy SHALL be 1 exactly in RUN.
REQ-024 Boundary cases:
  - A < B gives q=0, r=A.
  - B=1 gives q=A, r=0.
  - A=0 gives q=0, r=0 after the full 32 cycles.
REQ-025 Back-to-back operation: a start accepted in the IDLE cycle immediately after DONE SHALL be handled normally.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL go to IDLE and clear all outputs: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.
REQ-028 Reset SHALL take priority over start in the same cycle.

Structure
REQ-029 A shared package SHALL hold the following:
  - the WIDTH=32 constant;
  - the state typedef/encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the DIV0_QUOTIENT=32'hFFFFFFFF constant.
REQ-030 One combinational sub-module, div_step, SHALL implement a single restoring step.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
REQ-031 The top level SHALL contain the FSM, the count, and the dividend, quotient and remainder registers.
REQ-032 The encoding 2'b11 SHALL recover to IDLE.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
  - A=100, B=7, start pulse -> busy high for 32 cycles; done in cycle 33; q=14, r=2, div_by_zero=0.
  - A=32'hFFFFFFFF, B=1 -> q=32'hFFFFFFFF, r=0; then A=32'hFFFFFFFF, B=32'hFFFFFFFF -> q=1, r=0.
  - A=5, B=9 -> q=0, r=5; A=0, B=3 -> q=0, r=0, latency still 33.
  - A=1234, B=0 -> done in cycle 1; q=32'hFFFFFFFF, r=1234, div_by_zero=1, busy never high.
  - A=1000, B=3; assert reset at RUN cycle 10; assert start again with A=9, B=4 during the reset cycle -> no done pulse; all outputs 0; FSM in IDLE.
  - A=50, B=6; reassert start with A=7, B=7 at RUN cycle 5 (ignored) -> result q=8, r=2; an immediate back-to-back start with A=7, B=7 -> q=1, r=0.
REQ-034 Every scenario SHALL also be checked against a reference model computing A/B and A%B.
